// File: rtl/select_zero_if.sv
// Request/result bus for the k-th zero locator.
// Master drives the request, slave returns the registered result.
interface select_zero_if #(
    parameter int W = 32
) ();
    localparam int LW = $clog2(W);

    logic          pass;
    logic          ready;
    logic [W-1:0]  x;
    logic [LW-1:0] k;
    logic          valid_r;
    logic          found_r;
    logic [LW-1:0] pos_r;
    logic [LW:0]   zeros_r;

    modport master (
        output pass,
        output x,
        output k,
        input  ready,
        input  valid_r,
        input  found_r,
        input  pos_r,
        input  zeros_r
    );

    modport slave (
        input  pass,
        input  x,
        input  k,
        output ready,
        output valid_r,
        output found_r,
        output pos_r,
        output zeros_r
    );
endinterface

// File: rtl/select_zero.sv
// Locates the k-th zero bit (LSB-first) of a W-bit word, one nibble per cycle.
// Optional macro SELECT_ZERO_EARLY_EXIT_EN: finish on the nibble holding the hit.
module select_zero #(
    parameter int W = 32
) (
    input  logic        clk,
    input  logic        rst,
    select_zero_if.slave bus
);
    localparam int LW = $clog2(W);
    localparam int NW = LW - 2;
    localparam int N  = W / 4;

`ifdef SELECT_ZERO_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  x_r;
    logic [LW-1:0] k_r;
    logic [LW:0]   acc;
    logic [NW-1:0] nib_idx;
    logic          found_q;
    logic [LW-1:0] pos_q;

    logic          valid_o;
    logic          found_o;
    logic [LW-1:0] pos_o;
    logic [LW:0]   zeros_o;

    logic [3:0]    d;
    logic [2:0]    z;
    logic [2:0]    cnt;
    logic [LW:0]   acc_nx;
    logic          hit;
    logic [1:0]    rank;
    logic [1:0]    bit_sel;
    logic [LW-1:0] hit_pos;
    logic          last;

    assign bus.ready   = (state == IDLE);
    assign bus.valid_r = valid_o;
    assign bus.found_r = found_o;
    assign bus.pos_r   = pos_o;
    assign bus.zeros_r = zeros_o;

    // Current nibble: zero count, hit test and in-nibble position of the target zero
    always_comb begin
        d = x_r[{nib_idx, 2'b00} +: 4];
        z = '0;
        for (int b = 0; b < 4; b++) begin
            z = z + {2'b00, ~d[b]};
        end
        acc_nx = acc + {{(LW-2){1'b0}}, z};
        hit    = !found_q && (acc_nx > {1'b0, k_r});
        // target is below 4 inside the nibble, so low two bits suffice
        rank    = k_r[1:0] - acc[1:0];
        cnt     = '0;
        bit_sel = '0;
        for (int b = 0; b < 4; b++) begin
            if (!d[b]) begin
                if (cnt == {1'b0, rank}) begin
                    bit_sel = 2'(b);
                end
                cnt = cnt + 3'd1;
            end
        end
        hit_pos = {nib_idx, bit_sel};
        last    = (nib_idx == NW'(N - 1));
    end

    // Control FSM with registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            x_r     <= '0;
            k_r     <= '0;
            acc     <= '0;
            nib_idx <= '0;
            found_q <= 1'b0;
            pos_q   <= '0;
            valid_o <= 1'b0;
            found_o <= 1'b0;
            pos_o   <= '0;
            zeros_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    valid_o <= 1'b0;
                    if (bus.pass) begin
                        x_r     <= bus.x;
                        k_r     <= bus.k;
                        acc     <= '0;
                        nib_idx <= '0;
                        found_q <= 1'b0;
                        pos_q   <= '0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    acc     <= acc_nx;
                    nib_idx <= nib_idx + 1'b1;
                    if (hit) begin
                        found_q <= 1'b1;
                        pos_q   <= hit_pos;
                    end
                    if (last || (EARLY && hit)) begin
                        state   <= DONE;
                        valid_o <= 1'b1;
                        found_o <= found_q | hit;
                        pos_o   <= hit ? hit_pos : pos_q;
                        zeros_o <= acc_nx;
                    end
                end
                DONE: begin
                    valid_o <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    valid_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_select_zero.sv
// Scoreboard bench for select_zero (W=32).
// Expected results come from a bit-serial reference model.
module tb_select_zero;
    localparam int W  = 32;
    localparam int LW = 5;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    select_zero_if #(.W(W)) bus ();

    select_zero #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic          f;
        logic [LW-1:0] p;
        logic [LW:0]   z;
        int            lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t model(logic [W-1:0] xv, logic [LW-1:0] kv);
        exp_t e;
        int   cnt;
        int   top;
        cnt   = 0;
        e.f   = 1'b0;
        e.p   = '0;
        e.lat = N + 1;
        for (int i = 0; i < W; i++) begin
            if (!xv[i]) begin
                if (!e.f && cnt == int'(kv)) begin
                    e.f = 1'b1;
                    e.p = LW'(i);
                end
                cnt++;
            end
        end
        e.z = (LW+1)'(cnt);
`ifdef SELECT_ZERO_EARLY_EXIT_EN
        if (e.f) begin
            top   = (int'(e.p) / 4) * 4 + 3;
            e.lat = int'(e.p) / 4 + 2;
            cnt   = 0;
            for (int i = 0; i <= top; i++) begin
                if (!xv[i]) cnt++;
            end
            e.z = (LW+1)'(cnt);
        end
`else
        top = 0;
`endif
        return e;
    endfunction

    // Present a request at the negedge and accept it on the next posedge.
    // Returns #1 after the accept edge, i.e. in cycle T+1.
    task automatic accept(input logic [W-1:0] xv, input logic [LW-1:0] kv);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready: ready=%b required 1", bus.ready);
        end
        bus.pass = 1'b1;
        bus.x    = xv;
        bus.k    = kv;
        @(posedge clk);
        q.push_back(model(xv, kv));
        #1;
        bus.pass = 1'b0;
    endtask

    // Wait for valid_r from cycle T+1 and compare against the queue head.
    // Returns in the cycle after the result pulse.
    task automatic wait_result(input string nm);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (!bus.valid_r && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = q.pop_front();
        total++;
        if (bus.valid_r !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: no valid_r within %0d cycles", nm, cyc);
            return;
        end
        total += 4;
        if (cyc !== e.lat) begin
            bad++;
            $display("FAIL %s_lat: got T+%0d required T+%0d", nm, cyc, e.lat);
        end
        if (bus.found_r !== e.f) begin
            bad++;
            $display("FAIL %s_found: got %b required %b", nm, bus.found_r, e.f);
        end
        if (bus.pos_r !== e.p) begin
            bad++;
            $display("FAIL %s_pos: got %0d required %0d", nm, bus.pos_r, e.p);
        end
        if (bus.zeros_r !== e.z) begin
            bad++;
            $display("FAIL %s_zeros: got %0d required %0d", nm, bus.zeros_r, e.z);
        end
        @(posedge clk);
        #1;
        total += 2;
        if (bus.valid_r !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: valid_r=%b required 0", nm, bus.valid_r);
        end
        if (bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: ready=%b required 1", nm, bus.ready);
        end
        total++;
        if (bus.found_r !== e.f || bus.pos_r !== e.p) begin
            bad++;
            $display("FAIL %s_hold: found=%b pos=%0d required %b %0d",
                     nm, bus.found_r, bus.pos_r, e.f, e.p);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.pass = 1'b0;
        bus.x    = '0;
        bus.k    = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.valid_r, bus.found_r, bus.pos_r, bus.zeros_r, bus.ready}
            !== {1'b0, 1'b0, 5'd0, 6'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: v=%b f=%b p=%0d z=%0d rdy=%b required 0 0 0 0 1",
                     bus.valid_r, bus.found_r, bus.pos_r, bus.zeros_r, bus.ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        accept(32'hFFFF_FFFE, 5'd0);
        wait_result("lsb_zero");
        accept(32'h0000_0000, 5'd31);
        wait_result("all_zero");
        accept(32'hFFFF_FFFF, 5'd0);
        wait_result("no_zero");
        accept(32'h0F0F_0F0F, 5'd5);
        wait_result("nibbles");
        accept(32'h0F0F_0F0F, 5'd16);
        wait_result("k_past_end");
    endtask

    task automatic test_ignore_busy();
        int   cyc;
        int   busy_bad;
        exp_t e;
        accept(32'hFFFF_FF0F, 5'd2);
        cyc      = 1;
        busy_bad = 0;
        while (!bus.valid_r && cyc < 40) begin
            if (bus.ready !== 1'b0) busy_bad++;
            if (cyc == 3) begin
                bus.pass = 1'b1;
                bus.x    = '0;
                bus.k    = '0;
            end else begin
                bus.pass = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.pass = 1'b0;
        if (bus.ready !== 1'b0) busy_bad++;
        total++;
        if (busy_bad != 0) begin
            bad++;
            $display("FAIL busy_ready: ready high in %0d busy cycles required 0", busy_bad);
        end
        e = q.pop_front();
        total++;
        if (bus.valid_r !== 1'b1 || cyc != e.lat || bus.found_r !== 1'b1
            || bus.pos_r !== 5'd6 || bus.zeros_r !== e.z) begin
            bad++;
            $display("FAIL busy_result: v=%b T+%0d f=%b p=%0d z=%0d required 1 T+%0d 1 6 %0d",
                     bus.valid_r, cyc, bus.found_r, bus.pos_r, bus.zeros_r, e.lat, e.z);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.ready !== 1'b1 || bus.valid_r !== 1'b0) begin
            bad++;
            $display("FAIL busy_after: ready=%b valid=%b required 1 0", bus.ready, bus.valid_r);
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        accept(32'h0000_0000, 5'd7);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        void'(q.pop_front());
        total++;
        if ({bus.valid_r, bus.found_r, bus.pos_r, bus.zeros_r}
            !== {1'b0, 1'b0, 5'd0, 6'd0}) begin
            bad++;
            $display("FAIL midrst_clear: v=%b f=%b p=%0d z=%0d required all 0",
                     bus.valid_r, bus.found_r, bus.pos_r, bus.zeros_r);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.valid_r !== 1'b0) seen++;
        end
        total++;
        if (seen != 0 || bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_quiet: valid pulses=%0d ready=%b required 0 1", seen, bus.ready);
        end
        accept(32'h7FFF_FFFF, 5'd0);
        wait_result("after_rst");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.pass = 1'b1;
        bus.x    = 32'h00FF_00F0;
        bus.k    = 5'd9;
        @(posedge clk);
        q.push_back(model(32'h00FF_00F0, 5'd9));
        #1;
        bus.x = 32'hF0F0_FFFF;
        bus.k = 5'd3;
        wait_result("b2b_first");
        @(posedge clk);
        q.push_back(model(32'hF0F0_FFFF, 5'd3));
        #1;
        bus.pass = 1'b0;
        wait_result("b2b_second");
    endtask

    task automatic test_random();
        logic [W-1:0]  xv;
        logic [LW-1:0] kv;
        for (int i = 0; i < 12; i++) begin
            xv = $urandom() | $urandom();
            kv = LW'($urandom_range(0, 12));
            accept(xv, kv);
            wait_result("random");
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_busy();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/select_zero.md
Name: select_zero

Overview:
- Inverse of the zero-count block: instead of reducing a word to its zero count, locates the k-th zero bit (0-based, LSB-first) in a W-bit word.
- Multi-cycle iterative engine that scans one nibble per cycle using a per-nibble zero-count lookup and a running accumulator.
- Used downstream of the zero-count path for free-slot allocation and bitmap indexing.

Parameters:
- W, 32, word width; must be a multiple of 4 and at least 8; nibble count N = W/4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pass  in  1  request strobe; accepted only when ready=1
- ready  out  1  combinational; high exactly when FSM is in IDLE
- x  in  W  word to search; sampled on accept
- k  in  $clog2(W)  0-based rank of the zero to find; sampled on accept
- valid_r  out  1  registered one-cycle result pulse
- found_r  out  1  registered; 1 if k-th zero exists
- pos_r  out  $clog2(W)  registered bit position of the k-th zero
- zeros_r  out  $clog2(W)+1  registered zero count over the nibbles scanned

Behaviour:
- Reset (asynchronous, active-high): FSM=IDLE; valid_r=0, found_r=0, pos_r=0, zeros_r=0; internal x_r, k_r, acc, nib_idx cleared.
- States:
  - IDLE: ready=1. On pass: capture x->x_r, k->k_r; clear acc, nib_idx, found flag; go SCAN. Without pass, stay.
  - SCAN: nibble d = x_r[nib_idx*4 +: 4]; z = zeros(d), 0..4.
    - If not yet found and acc+z > k_r: found=1; pos = nib_idx*4 + bit index of the (k_r-acc)-th zero inside d, counted LSB-first.
    - acc += z every SCAN cycle.
    - Exit to DONE after nibble N-1 (see Optional Feature for early exit). Otherwise nib_idx++.
  - DONE: on entry, load found_r, pos_r (0 if not found), zeros_r=acc; valid_r=1 for exactly this cycle. Next state IDLE.
- Latency: accept at cycle T -> SCAN T+1..T+N -> valid_r high at T+N+1 (T+9 for W=32) -> ready high at T+N+2.
- Throughput: one request per N+2 cycles. With pass held high continuously, the next request is accepted on the first cycle ready returns.
- pass while ready=0 is ignored: no queuing, and x/k changes do not disturb the operation in flight.
- found_r, pos_r, zeros_r hold their values until the next DONE. valid_r is 0 outside DONE.
- k_r >= total zeros: found_r=0, pos_r=0; zeros_r still reports the accumulated count.
- acc width is $clog2(W)+1 and cannot overflow (max W).
- rst asserted mid-SCAN or in DONE: operation is abandoned immediately, outputs cleared, and no valid_r pulse is produced for that request.

Optional Feature:
- Macro: SELECT_ZERO_EARLY_EXIT_EN.
- Defined: SCAN goes to DONE in the same cycle the hit nibble j is processed. valid_r is high at T+j+2. zeros_r counts nibbles 0..j only, including the hit nibble. A miss still scans all N nibbles.
- Undefined: fixed latency N+1. zeros_r always equals the total zero count of x.

Test Plan:
- x=32'hFFFF_FFFE, k=0, accept at T -> valid_r at T+9; found_r=1, pos_r=0, zeros_r=1. With EARLY_EXIT_EN: valid_r at T+2, zeros_r=1.
- x=32'h0000_0000, k=31 -> found_r=1, pos_r=31, zeros_r=32, valid_r at T+9, for both build options.
- x=32'hFFFF_FFFF, k=0 -> found_r=0, pos_r=0, zeros_r=0, valid_r at T+9, for both build options.
- x=32'h0F0F_0F0F, k=5 -> found_r=1, pos_r=13. Without EARLY_EXIT_EN: zeros_r=16, valid_r at T+9. With EARLY_EXIT_EN: zeros_r=8, valid_r at T+5.
- Accept x=32'hFFFF_FF0F, k=2. Drive pass with x=0, k=0 at T+3 -> ignored; ready=0 during T+1..T+9; result found_r=1, pos_r=6.
- Accept x=0, k=7; pulse rst at T+4 -> outputs 0 immediately, no valid_r, ready=1 after reset release. Then x=32'h7FFF_FFFF, k=0 -> pos_r=31, found_r=1.
